// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences each MEM-stage data access against a variable-latency memory port.
// While an access is outstanding the upstream pipeline is stalled and the
// MEM/WB register receives bubbles. The load result is presented on RD in the
// single DONE cycle, which is the cycle in which the pipeline advances. A wait
// counter aborts accesses that receive no response within TIMEOUT cycles.
//
// Handshake: mem_req is a level request. Once raised, mem_req, mem_we,
// mem_addr and mem_wdata stay stable until the memory returns a single-cycle
// mem_ready pulse (or the timeout fires). mem_rdata is only meaningful in the
// mem_ready cycle. mem_ready is ignored outside BUSY.
//
// Ports
//   CLK, rst        clock (rising edge) / asynchronous active-low reset
//   MemReadM        MEM-stage instruction is a load
//   MemWriteM       MEM-stage instruction is a store (wins if both are set)
//   ALUOutM         byte address of the access
//   WriteDataM      store data
//   mem_req/we/addr/wdata  registered request to memory
//   mem_rdata       read data from memory
//   mem_ready       completion pulse from memory
//   RD              registered load result for MEM/WB
//   StallM          freezes PC, IF/ID, ID/EX, EX/MEM
//   BubbleW         same as StallM; gates write-back controls into MEM/WB
//   mem_err         sticky timeout flag, cleared only by reset
//   state_o         current FSM state (0 IDLE, 1 BUSY, 2 DONE) for debug
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] RD,
  output logic        StallM,
  output logic        BubbleW,
  output logic        mem_err,
  output logic [1:0]  state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rd_q, rd_d;
  logic               err_q, err_d;
  logic               pending;

  assign pending = MemReadM | MemWriteM;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (pending) begin
          addr_d  = ALUOutM;
          wdata_d = WriteDataM;
          // A simultaneous read+write request is handled as a store.
          we_d    = MemWriteM;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A response in the last BUSY cycle takes priority over the timeout.
        if (mem_ready) begin
          req_d   = 1'b0;
          if (!we_q) rd_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rd_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Not stalling in DONE lets the pipeline advance exactly once per access;
  // the following IDLE cycle already sees the next instruction.
  assign StallM    = ((state_q == IDLE) && pending) || (state_q == BUSY);
  assign BubbleW   = StallM;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign RD        = rd_q;
  assign mem_err   = err_q;
  assign state_o   = state_q;

endmodule
